// File: rtl/switch_output_guard.sv
// Gate-driver protection stage: registers the complementary switch bus, enforces
// per-switch minimum pulse width, leg interlock and a latched fault shutdown.
module switch_output_guard #(
  parameter int LevelCount = 2,
  parameter int BIT_WIDTH  = 16
) (
  input  logic                    MClk,
  input  logic                    RstN,
  input  logic [LevelCount*2-1:0] SIn,
  input  logic                    Enable,
  input  logic                    FaultN,
  input  logic                    FaultClear,
  input  logic [BIT_WIDTH-1:0]    MinPulseCount,
  output logic [LevelCount*2-1:0] SOut,
  output logic [1:0]              FaultCode,
  output logic [1:0]              State
);

  localparam int Width = LevelCount * 2;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Arm   = 2'd1,
    Run   = 2'd2,
    Fault = 2'd3
  } stateT;

  stateT                 stateReg;
  logic                  faultMetaReg;
  logic                  faultSyncReg;
  logic [LevelCount-1:0] legOverlap;
  logic                  shootThrough;
  logic                  faultHit;
  logic                  stayRun;
  logic [BIT_WIDTH-1:0]  holdLoad;

  // Flops reset to 0 so the stage starts out seeing an active fault.
  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      faultMetaReg <= 1'b0;
      faultSyncReg <= 1'b0;
    end else begin
      faultMetaReg <= FaultN;
      faultSyncReg <= faultMetaReg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LevelCount; gi++) begin : gLeg
      assign legOverlap[gi] = SIn[2*gi+1] & SIn[2*gi];
    end
  endgenerate

  assign shootThrough = |legOverlap;
  assign faultHit     = !faultSyncReg || shootThrough;
  // True exactly when the sequencer will still be in RUN after this edge.
  assign stayRun      = (stateReg == Run) && Enable && !faultHit;
  assign holdLoad     = (MinPulseCount == '0) ? '0 : MinPulseCount - BIT_WIDTH'(1);

  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      stateReg  <= Idle;
      FaultCode <= 2'b00;
    end else begin
      case (stateReg)
        Idle: begin
          if (Enable && faultSyncReg) stateReg <= Arm;
        end
        Arm, Run: begin
          if (faultHit) begin
            stateReg  <= Fault;
            FaultCode <= {shootThrough, !faultSyncReg};
          end else if (!Enable) begin
            stateReg <= Idle;
          end else if (stateReg == Arm && SIn == '0) begin
            stateReg <= Run;
          end
        end
        Fault: begin
          if (FaultClear && faultSyncReg && !shootThrough) begin
            stateReg  <= Idle;
            FaultCode <= 2'b00;
          end
        end
        default: stateReg <= Idle;
      endcase
    end
  end

  assign State = stateReg;

  generate
    for (gi = 0; gi < Width; gi++) begin : gBit
      localparam int Comp = gi ^ 1;
      logic                 outBitReg;
      logic [BIT_WIDTH-1:0] holdCntReg;
      logic                 accept;

      // A rise must wait for the other switch of the leg to be off at the pins.
      assign accept = (holdCntReg == '0) && !(SIn[gi] && !outBitReg && SOut[Comp]);

      always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
          outBitReg  <= 1'b0;
          holdCntReg <= '0;
        end else if (!stayRun) begin
          outBitReg  <= 1'b0;
          holdCntReg <= '0;
        end else if (accept && (SIn[gi] != outBitReg)) begin
          outBitReg  <= SIn[gi];
          holdCntReg <= holdLoad;
        end else if (holdCntReg != '0) begin
          holdCntReg <= holdCntReg - BIT_WIDTH'(1);
        end
      end

      assign SOut[gi] = outBitReg;
    end
  endgenerate

endmodule

// File: tb/tb_switch_output_guard.sv
// Self-checking bench for switch_output_guard: vector table plus hand-written
// multi-cycle sequences, expectations queued at drive time and popped after the edge.
module tb_switch_output_guard;

  logic        MClk;
  logic        RstN;
  logic [3:0]  SIn;
  logic        Enable;
  logic        FaultN;
  logic        FaultClear;
  logic [15:0] MinPulseCount;
  logic [3:0]  SOut;
  logic [1:0]  FaultCode;
  logic [1:0]  State;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] sOut;
    logic [1:0] state;
    logic [1:0] code;
    string      name;
  } expT;

  typedef struct {
    logic [3:0]  sIn;
    logic        en;
    logic [15:0] mpc;
    logic [3:0]  eSOut;
    logic [1:0]  eState;
  } vecT;

  expT expQ[$];
  vecT vecs[13];

  switch_output_guard #(.LevelCount(2), .BIT_WIDTH(16)) dut (
    .MClk(MClk),
    .RstN(RstN),
    .SIn(SIn),
    .Enable(Enable),
    .FaultN(FaultN),
    .FaultClear(FaultClear),
    .MinPulseCount(MinPulseCount),
    .SOut(SOut),
    .FaultCode(FaultCode),
    .State(State)
  );

  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b required %b", nm, act, req);
    end
  endtask

  // One clocked transaction: drive, queue expectation, sample 1 after the edge.
  task automatic cyc(input logic [3:0] sIn, input logic en, input logic fn, input logic fc,
                     input logic [3:0] eSOut, input logic [1:0] eState, input logic [1:0] eCode,
                     input string nm);
    expT e;
    SIn        = sIn;
    Enable     = en;
    FaultN     = fn;
    FaultClear = fc;
    expQ.push_back('{sOut: eSOut, state: eState, code: eCode, name: nm});
    @(posedge MClk);
    #1;
    e = expQ.pop_front();
    $display("txn %s: SIn=%b En=%b FN=%b FC=%b -> SOut=%b State=%0d Code=%b",
             e.name, sIn, en, fn, fc, SOut, State, FaultCode);
    check({e.name, ".SOut"}, SOut, e.sOut);
    check({e.name, ".State"}, {2'b00, State}, {2'b00, e.state});
    check({e.name, ".Code"}, {2'b00, FaultCode}, {2'b00, e.code});
  endtask

  initial begin
    // Power-up sequence, RUN entry, latency and interlock with no hold.
    vecs[0]  = '{4'b0000, 1'b1, 16'd1, 4'b0000, 2'd0};
    vecs[1]  = '{4'b0000, 1'b1, 16'd1, 4'b0000, 2'd0};
    vecs[2]  = '{4'b0001, 1'b1, 16'd1, 4'b0000, 2'd1};
    vecs[3]  = '{4'b0001, 1'b1, 16'd1, 4'b0000, 2'd1};
    vecs[4]  = '{4'b0000, 1'b1, 16'd1, 4'b0000, 2'd2};
    vecs[5]  = '{4'b0110, 1'b1, 16'd1, 4'b0110, 2'd2};
    vecs[6]  = '{4'b1001, 1'b1, 16'd1, 4'b0000, 2'd2};
    vecs[7]  = '{4'b1001, 1'b1, 16'd1, 4'b1001, 2'd2};
    vecs[8]  = '{4'b0000, 1'b1, 16'd1, 4'b0000, 2'd2};
    vecs[9]  = '{4'b1010, 1'b1, 16'd1, 4'b1010, 2'd2};
    vecs[10] = '{4'b1010, 1'b0, 16'd5, 4'b0000, 2'd0};
    vecs[11] = '{4'b0000, 1'b1, 16'd5, 4'b0000, 2'd1};
    vecs[12] = '{4'b0000, 1'b1, 16'd5, 4'b0000, 2'd2};

    RstN = 1'b0; SIn = 4'b0000; Enable = 1'b1; FaultN = 1'b1;
    FaultClear = 1'b0; MinPulseCount = 16'd1;
    repeat (2) @(posedge MClk);
    #1;
    check("reset.SOut", SOut, 4'b0000);
    check("reset.State", {2'b00, State}, 4'd0);
    check("reset.Code", {2'b00, FaultCode}, 4'd0);
    RstN = 1'b1;

    for (int i = 0; i < 13; i++) begin
      MinPulseCount = vecs[i].mpc;
      cyc(vecs[i].sIn, vecs[i].en, 1'b1, 1'b0, vecs[i].eSOut, vecs[i].eState, 2'b00,
          $sformatf("vec%0d", i));
    end

    // MinPulseCount=5 with SIn[0] toggling every cycle: SOut[0] moves every 5th edge.
    for (int j = 0; j < 20; j++) begin
      cyc({3'b000, (j % 2 == 0)}, 1'b1, 1'b1, 1'b0,
          ((j / 5) % 2 == 0) ? 4'b0001 : 4'b0000, 2'd2, 2'b00, $sformatf("tog%0d", j));
    end
    for (int j = 0; j < 5; j++)
      cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 2'b00, $sformatf("settle%0d", j));

    // Re-arm with MinPulseCount=8 for the leg interlock case.
    cyc(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b00, "leg.idle");
    MinPulseCount = 16'd8;
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 2'b00, "leg.arm");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 2'b00, "leg.run");
    cyc(4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd2, 2'b00, "leg.t0");
    cyc(4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd2, 2'b00, "leg.t1");
    for (int j = 2; j < 8; j++)
      cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd2, 2'b00, $sformatf("leg.t%0d", j));
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 2'b00, "leg.t8");
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd2, 2'b00, "leg.t9");
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd2, 2'b00, "leg.t10");

    // Asynchronous reset in the middle of the held SOut[0] pulse.
    #2;
    RstN = 1'b0;
    #1;
    check("arst.SOut", SOut, 4'b0000);
    check("arst.State", {2'b00, State}, 4'd0);
    MinPulseCount = 16'd1;
    @(posedge MClk);
    #1;
    RstN = 1'b1;
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b00, "rel.e0");
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b00, "rel.e1");
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 2'b00, "rel.e2");
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 2'b00, "rel.e3");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 2'b00, "rel.e4");

    // Shoot-through on leg 1, clear refused while it persists.
    cyc(4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 2'b00, "st.pre");
    cyc(4'b1100, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd3, 2'b10, "st.hit");
    cyc(4'b1100, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd3, 2'b10, "st.clrIgnored");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd3, 2'b10, "st.hold");
    cyc(4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 2'b00, "st.clear");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 2'b00, "st.arm");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 2'b00, "st.run");

    // One-cycle external fault; Enable drops as the synced fault arrives.
    cyc(4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd2, 2'b00, "ext.k");
    cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd2, 2'b00, "ext.k1");
    cyc(4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 2'b01, "ext.k2");
    cyc(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 2'b00, "ext.clear");

    // Fault while in IDLE keeps the stage there and is not latched.
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'b00, "idf.a");
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'b00, "idf.b");
    cyc(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'b00, "idf.c");
    cyc(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'b00, "idf.d");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b00, "idf.e");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b00, "idf.f");
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 2'b00, "idf.arm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_output_guard.md
# switch_output_guard

Protection stage between the interleave/level PWM generator and the gate-driver pins. It registers the complementary switch bus and enforces three rules: a per-switch minimum on/off time, no overlap within a leg, and a latched shutdown on external fault or shoot-through. A four-state arm/run/fault sequencer controls it. All outputs are driven low whenever the stage is not running.

## Interface
- LevelCount, 2: number of legs; leg i is switch pair {SIn[2i+1] high-side, SIn[2i] low-side}
- BIT_WIDTH, 16: width of the minimum-pulse counter and its limit
- MClk  input  1  system clock; all logic on rising edge
- RstN  input  1  reset, asynchronous assert, active-low
- SIn  input  LevelCount*2  raw switch commands from the level generators
- Enable  input  1  run request, synchronous to MClk
- FaultN  input  1  external fault, active-low, asynchronous; passes through a 2-flop synchronizer
- FaultClear  input  1  single-cycle request to leave FAULT
- MinPulseCount  input  BIT_WIDTH  minimum cycles between transitions of one output bit; static while State is RUN
- SOut  output  LevelCount*2  guarded switch outputs, registered
- FaultCode  output  2  sticky fault cause: bit0 external, bit1 shoot-through
- State  output  2  sequencer state: 0 IDLE, 1 ARM, 2 RUN, 3 FAULT

## Operation
- Reset values:
  - SOut=0, FaultCode=0, State=IDLE.
  - Synchronizer flops reset to 0. The synced fault is therefore active out of reset.
  - All hold counters reset to 0.
- Definitions:
  - fsync: the synchronized FaultN.
  - st: shoot-through. It is true when any leg has both SIn bits at 1.
- State transitions:
  - IDLE -> ARM: Enable=1 and fsync=1.
  - ARM -> RUN: SIn is all-zero in the same cycle. This prevents starting mid-pulse.
  - ARM or RUN -> IDLE: Enable=0.
  - ARM or RUN -> FAULT: fsync=0 or st=1.
  - FAULT -> IDLE: FaultClear=1, fsync=1 and st=0 in the same cycle. FaultCode clears on this transition.
  - FaultClear is ignored outside FAULT.
- Priority:
  - Fault beats Enable=0.
  - Enable=0 beats the ARM -> RUN exit.
  - A fault in IDLE is not latched, because IDLE cannot be left while fsync=0.
- FaultCode: on entry to FAULT, set bit0 if fsync=0 and bit1 if st=1. Both bits may be set.
- In IDLE, ARM and FAULT: SOut is 0 and all hold counters are 0.
- In RUN, for each bit b, candidate next value = SIn[b]. The candidate is rejected and SOut[b] is held when either of these is true:
  - The hold counter of bit b is nonzero.
  - The candidate is a rise and the complement bit of the same leg is currently 1 in SOut.
- On an accepted change of SOut[b]:
  - The counter loads MinPulseCount-1 (saturating at 0).
  - Otherwise the counter decrements toward 0.
  - MinPulseCount of 0 or 1 means no hold.
- Leaving RUN for any state drives SOut to 0 on that same edge. This bypasses any hold in progress.

## Timing
- SIn -> SOut latency: 1 cycle in RUN.
- After SOut[b] changes at edge t, it cannot change again before edge t+MinPulseCount.
- Shoot-through:
  - st is sampled at edge k.
  - At edge k, State goes to FAULT and SOut goes to 0.
  - The overlapping value never reaches SOut.
- External fault:
  - FaultN goes low before edge k.
  - fsync goes low after edge k+1.
  - At edge k+2, State goes to FAULT and SOut goes to 0.
- Exit from FAULT: IDLE at the clear edge, then ARM no earlier than 1 cycle later, then RUN no earlier than 1 further cycle.
- Reset asserted mid-pulse: SOut is 0 immediately, without waiting for a clock edge.

## Test plan
- Reset then Enable=1 with FaultN=1:
  - Required: IDLE at edges 0-1; ARM once fsync=1 (edge 2 after reset).
  - Required: RUN at the first edge with SIn=0.
  - Then apply SIn=4'b0110 -> SOut=4'b0110 one cycle later.
- MinPulseCount=5, RUN, SIn[0] toggled every cycle:
  - Required: SOut[0] changes at most once per 5 edges.
  - Required: SOut[0] follows the current SIn[0] when each hold expires.
- Leg 0: SOut=2'b10 held by MinPulseCount=8; SIn switches to 2'b01 after 2 cycles:
  - Required: SOut[0] stays 0 until SOut[1] falls.
  - Required: SOut[0] rises 1 edge later.
  - Required: never 2'b11.
- SIn=4'b1100 for 1 cycle in RUN:
  - Required: at that edge, State=3, FaultCode=2'b10, SOut=0.
  - Required: FaultClear while st=1 is ignored.
  - Required: FaultClear after st=0 -> IDLE, FaultCode=0.
- FaultN pulsed low 1 cycle in RUN, with Enable dropped in the cycle fsync goes low:
  - Required: FAULT (not IDLE) at edge k+2.
  - Required: FaultCode=2'b01.
- RstN asserted during a held pulse:
  - Required: SOut=0 and State=0 asynchronously.
  - Required: after release, RUN again only once SIn=0.
